sipo_stream: RTL and testbench
==============================

SIPO_STREAM -- requirements
Module: sipo_stream

Interface
REQ-001 SHALL have parameter width_p, default 8, bits per input beat.
REQ-002 SHALL have parameter depth_p, default 8, beats per output word (>=2).
REQ-003 SHALL have parameter first_lsb_p, default 1: 1 = first beat lands in element 0; 0 = first beat lands in element depth_p-1.
REQ-004 SHALL have port clk_i  input  1  sole clock, all state on posedge.
REQ-005 SHALL have port reset_i  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port valid_i  input  1  input beat valid.
REQ-007 SHALL have port ready_o  output  1  block can accept a beat or flush this cycle.
REQ-008 SHALL have port data_i  input  width_p  input beat.
REQ-009 SHALL have port flush_i  input  1  request to emit the partial word.
REQ-010 SHALL have port valid_o  output  1  output word valid.
REQ-011 SHALL have port ready_i  input  1  downstream accepts the word.
REQ-012 SHALL have port data_o  output  width_p*depth_p  assembled word; element k occupies bits [k*width_p +: width_p].
REQ-013 SHALL have port count_o  output  $clog2(depth_p+1)  number of valid elements in data_o; meaningful only while valid_o=1.

Function
REQ-014 SHALL use a 2-state FSM: FILL (assembling, valid_o=0) and HOLD (word presented, valid_o=1).
REQ-015 SHALL drive ready_o = !valid_o | ready_i, combinationally.
REQ-016 SHALL accept a beat on a posedge where valid_i & ready_o, writing data_i into the next element and incrementing the fill count.
REQ-017 SHALL, when the accepted beat is the depth_p-th beat, enter HOLD after that same edge with count_o=depth_p (one-cycle latency from the last beat).
REQ-018 SHALL keep data_o and count_o stable while valid_o & !ready_i, and ignore valid_i and flush_i in that state.
REQ-019 SHALL complete the output handshake on a posedge with valid_o & ready_i; a beat accepted on the same edge SHALL become element "first" of a new word with fill count 1 (zero bubble).
REQ-020 SHALL treat flush_i & ready_o with fill count>0, or with a beat accepted on the same edge, as a flush: enter HOLD with count_o = fill count including that beat.
REQ-021 SHALL zero every element of a flushed word that received no beat.
REQ-022 SHALL ignore flush_i when the fill count is 0 and no beat is accepted.
REQ-023 SHALL treat flush_i coincident with the depth_p-th beat as a normal full word.
REQ-024 SHALL, with first_lsb_p=0, fill elements in order depth_p-1 down to 0; a flushed partial word then occupies the top count_o elements.
REQ-025 SHALL clear all unfilled elements when a new word starts, so that no stale data from the previous word appears in it.

Reset
REQ-026 SHALL, on reset_i=1 and independent of clk_i, force FILL, fill count 0, valid_o=0, count_o=0, data_o=0.
REQ-027 SHALL discard any partial or held word when reset is asserted mid-operation; ready_o SHALL read 1 throughout reset.
REQ-028 SHALL resume accepting beats on the first posedge after reset_i deasserts.

Structure
REQ-029 SHALL declare the FSM state enum (sipo_state_e: FILL, HOLD) in the shared package systolic_pkg.
REQ-030 SHALL be a single module with no sub-modules; the element register file and counter are inline.
REQ-031 SHALL reject depth_p<2 or width_p<1 with an elaboration-time assertion.

Verification (width_p=1, depth_p=8, first_lsb_p=1 unless stated)
REQ-032 SHALL test: beats 1,0,1,0,0,0,0,1 with ready_i=1 -> valid_o high one cycle after the 8th beat, data_o=8'b10000101, count_o=8.
REQ-033 SHALL test: the same stream with ready_i=0 for 3 cycles after completion -> data_o held at 8'b10000101, ready_o=0, a 9th beat offered is not taken; ready_i=1 -> handshake, and that beat is accepted on the same edge as element 0.
REQ-034 SHALL test: beats 1,1,1 then flush_i -> valid_o with data_o=8'b00000111, count_o=3.
REQ-035 SHALL test: first_lsb_p=0, beats 1,0,1,0,0,0,0,1 -> data_o=8'b10100001.
REQ-036 SHALL test: two back-to-back words streamed with ready_i=1 continuously -> no idle cycle on ready_o, and the two outputs are exactly one 8-cycle period apart.
REQ-037 SHALL test: reset_i pulsed asynchronously after 5 beats -> valid_o=0 immediately; then 8 fresh beats produce the correct word with no residue from the aborted word.

Source files
------------

// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared types and helpers for the streaming blocks. Holds the
//               serial-in/parallel-out FSM state encoding and the fill-order
//               index mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    // FILL: assembling a word (valid_o low); HOLD: word presented (valid_o high)
    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } sipo_state_e;

    // Element slot written by the beat that arrives when fill_cnt beats are
    // already stored. LSB-first fills upward from 0, MSB-first downward from
    // depth-1.
    function automatic int fill_index(input int fill_cnt, input int depth,
                                      input bit first_lsb);
        return first_lsb ? fill_cnt : (depth - 1 - fill_cnt);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_stream.sv
`default_nettype none
// ============================================================================
// Module      : sipo_stream
// Description : Serial-in / parallel-out stream packer. Collects depth_p beats
//               of width_p bits into one word with valid/ready handshakes on
//               both sides. A flush emits a partial word with its unfilled
//               elements zeroed. A completed word can be handed off on the
//               same edge that accepts the first beat of the next word.
// Ports       : clk_i    - clock, all state on posedge
//               reset_i  - asynchronous active-high reset
//               valid_i  - input beat valid
//               ready_o  - a beat or flush can be taken this cycle
//               data_i   - input beat
//               flush_i  - emit the partial word
//               valid_o  - output word valid
//               ready_i  - downstream accepts the word
//               data_o   - assembled word, element k at [k*width_p +: width_p]
//               count_o  - number of valid elements (meaningful with valid_o)
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_stream
    import systolic_pkg::*;
#(
    parameter int width_p     = 8,
    parameter int depth_p     = 8,
    parameter int first_lsb_p = 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [width_p-1:0]             data_i,
    input  logic                           flush_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [width_p*depth_p-1:0]     data_o,
    output logic [$clog2(depth_p+1)-1:0]   count_o
);

    localparam int              CNT_W  = $clog2(depth_p + 1);
    localparam int              WORD_W = width_p * depth_p;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(depth_p);

    if ((depth_p < 2) || (width_p < 1)) begin : g_param_check
        $error("sipo_stream: depth_p must be >= 2 and width_p >= 1");
    end

    sipo_state_e         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   data_q, data_d;

    logic                accept;
    logic [CNT_W-1:0]    base_cnt;
    logic [WORD_W-1:0]   base_data;
    int                  slot;

    assign valid_o = (state_q == HOLD);
    assign ready_o = !valid_o || ready_i;
    assign accept  = valid_i && ready_o;
    assign data_o  = data_q;
    assign count_o = cnt_q;

    always_comb begin
        // A word leaving on this edge means the next word starts empty and
        // all-zero, so nothing from the departing word can leak into it.
        base_cnt  = (state_q == HOLD) ? '0 : cnt_q;
        base_data = (state_q == HOLD) ? '0 : data_q;
        slot      = fill_index(int'(base_cnt), depth_p, first_lsb_p != 0);

        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;

        // When ready_o is low a word is stalled: every input is ignored.
        if (ready_o) begin
            data_d = base_data;
            cnt_d  = base_cnt + {{(CNT_W-1){1'b0}}, accept};
            if (accept) begin
                for (int k = 0; k < depth_p; k++) begin
                    if (k == slot) begin
                        data_d[k*width_p +: width_p] = data_i;
                    end
                end
            end
            // A flush with nothing stored and no beat this edge has no effect.
            if ((cnt_d == FULL_CNT) || (flush_i && (cnt_d != '0))) begin
                state_d = HOLD;
            end else begin
                state_d = FILL;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sipo_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_stream
// Description : Self-checking bench for sipo_stream (width 1, depth 8). Two
//               instances, LSB-first and MSB-first, share one stimulus. A
//               reference model pushes expected words to a scoreboard as beats
//               are accepted; a monitor pops and compares on each handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_stream;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       valid_i;
    logic [0:0] data_i;
    logic       flush_i;
    logic       ready_i;

    logic       ready1, valid1, ready0, valid0;
    logic [7:0] data1, data0;
    logic [3:0] count1, count0;

    always #5 clk = ~clk;

    sipo_stream #(.width_p(1), .depth_p(8), .first_lsb_p(1)) u_dut_lsb (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready1),
        .data_i(data_i), .flush_i(flush_i), .valid_o(valid1),
        .ready_i(ready_i), .data_o(data1), .count_o(count1)
    );

    sipo_stream #(.width_p(1), .depth_p(8), .first_lsb_p(0)) u_dut_msb (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready0),
        .data_i(data_i), .flush_i(flush_i), .valid_o(valid0),
        .ready_i(ready_i), .data_o(data0), .count_o(count0)
    );

    typedef struct packed {
        logic [7:0] d1;
        logic [7:0] d0;
        logic [3:0] c;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         pop_cyc[$];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    logic [7:0] m_w1, m_w0;
    int         m_cnt;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_clear();
        m_w1  = '0;
        m_w0  = '0;
        m_cnt = 0;
    endtask

    task automatic model_push();
        sb.push_back('{d1: m_w1, d0: m_w0, c: 4'(m_cnt)});
        model_clear();
    endtask

    task automatic model_beat(input logic b);
        m_w1[m_cnt]     = b;
        m_w0[7 - m_cnt] = b;
        m_cnt++;
        if (m_cnt == 8) model_push();
    endtask

    task automatic model_flush();
        if (m_cnt > 0) model_push();
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset_i && valid1 && ready_i) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("word_lsb",   32'(data1),  32'(mon_e.d1));
                check("word_msb",   32'(data0),  32'(mon_e.d0));
                check("count_lsb",  32'(count1), 32'(mon_e.c));
                check("count_msb",  32'(count0), 32'(mon_e.c));
                check("valid_msb",  32'(valid0), 32'd1);
                pop_cyc.push_back(cyc);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic beat(input logic b, input logic fl);
        valid_i = 1'b1;
        data_i  = b;
        flush_i = fl;
        #3;
        check("ready_on_beat", 32'(ready1), 32'd1);
        @(posedge clk); #1;
        model_beat(b);
        if (fl) model_flush();
        valid_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] pat;

    initial begin
        reset_i = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        flush_i = 1'b0;
        ready_i = 1'b1;
        model_clear();

        // reset state
        #2;
        check("rst_valid", 32'(valid1), 32'd0);
        check("rst_ready", 32'(ready1), 32'd1);
        check("rst_count", 32'(count1), 32'd0);
        check("rst_data",  32'(data1),  32'd0);
        check("rst_data_msb", 32'(data0), 32'd0);
        repeat (2) @(posedge clk);
        #3 reset_i = 1'b0;
        step();

        // full word, ready_i high
        pat = 8'b10000101;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("t1_not_early", 32'(valid1), 32'd0);
            beat(pat[i], 1'b0);
        end
        check("t1_valid",    32'(valid1), 32'd1);
        check("t1_count",    32'(count1), 32'd8);
        check("t1_data_lsb", 32'(data1),  32'h85);
        check("t1_data_msb", 32'(data0),  32'hA1);
        step();
        check("t1_handoff", 32'(valid1), 32'd0);

        // stall, ignored inputs, zero-bubble restart
        ready_i = 1'b0;
        for (int i = 0; i < 8; i++) beat(pat[i], 1'b0);
        valid_i = 1'b1;
        data_i  = 1'b1;
        flush_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t2_hold_data",  32'(data1),  32'h85);
            check("t2_hold_count", 32'(count1), 32'd8);
            check("t2_hold_valid", 32'(valid1), 32'd1);
            check("t2_ready_low",  32'(ready1), 32'd0);
        end
        @(posedge clk); #1;
        flush_i = 1'b0;
        ready_i = 1'b1;
        #1;
        check("t2_ready_high", 32'(ready1), 32'd1);
        @(posedge clk); #1;
        model_beat(1'b1);
        valid_i = 1'b0;
        check("t2_restart_valid", 32'(valid1), 32'd0);
        check("t2_restart_count", 32'(count1), 32'd1);
        check("t2_restart_data",  32'(data1),  32'h01);
        flush_i = 1'b1;
        step();
        model_flush();
        flush_i = 1'b0;
        check("t2_flush1_count", 32'(count1), 32'd1);
        check("t2_flush1_msb",   32'(data0),  32'h80);
        step();

        // partial flush, empty flush, flush with the last beat
        for (int i = 0; i < 3; i++) beat(1'b1, 1'b0);
        flush_i = 1'b1;
        step();
        model_flush();
        flush_i = 1'b0;
        check("t3_flush_valid", 32'(valid1), 32'd1);
        check("t3_flush_count", 32'(count1), 32'd3);
        check("t3_flush_lsb",   32'(data1),  32'h07);
        check("t3_flush_msb",   32'(data0),  32'hE0);
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("t3_empty_flush", 32'(valid1), 32'd0);
        pat = 8'b10010110;
        for (int i = 0; i < 8; i++) beat(pat[i], i == 7);
        check("t3_flush_full_count", 32'(count1), 32'd8);
        check("t3_flush_full_data",  32'(data1),  32'h96);
        step();

        // back-to-back words
        pop_cyc.delete();
        for (int i = 0; i < 16; i++) beat(1'($urandom_range(0, 1)), 1'b0);
        step();
        check("t4_two_words", 32'(pop_cyc.size()), 32'd2);
        if (pop_cyc.size() == 2)
            check("t4_period", 32'(pop_cyc[1] - pop_cyc[0]), 32'd8);

        // asynchronous reset mid-word
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b0);
        #2 reset_i = 1'b1;
        #1;
        check("t5_rst_valid", 32'(valid1), 32'd0);
        check("t5_rst_count", 32'(count1), 32'd0);
        check("t5_rst_data",  32'(data1),  32'd0);
        check("t5_rst_msb",   32'(data0),  32'd0);
        check("t5_rst_ready", 32'(ready1), 32'd1);
        model_clear();
        @(posedge clk);
        #3 reset_i = 1'b0;
        step();
        pat = 8'b00100110;
        for (int i = 0; i < 8; i++) beat(pat[i], 1'b0);
        check("t5_word_lsb", 32'(data1), 32'h26);
        check("t5_word_msb", 32'(data0), 32'h64);
        step();

        repeat (2) step();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
